// File: rtl/light_dance_sequencer_pkg.sv
// Shared types for the LightDance sequencer: FSM state encodings and serial-input modes.
package light_dance_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLoad,
        StShift,
        StAdv,
        StDone
    } ld_state_e;

    typedef enum logic [1:0] {
        ModeZero = 2'b00,
        ModeOne  = 2'b01,
        ModeRot  = 2'b10,
        ModeTgl  = 2'b11
    } ld_mode_e;

    function automatic logic din_sel(input ld_mode_e mode, input logic msb, input logic tgl);
        logic d;
        unique case (mode)
            ModeZero: d = 1'b0;
            ModeOne:  d = 1'b1;
            ModeRot:  d = msb;
            ModeTgl:  d = tgl;
            default:  d = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ld_pattern_table.sv
// Pattern table: NUM_PATTERNS entries of {mode, data}, synchronous write, combinational read,
// synchronous active-low clear.
module ld_pattern_table #(
    parameter int unsigned NUM_PATTERNS = 8,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned AW           = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W+1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W+1:0] rdata_o
);

    logic [DATA_W+1:0] mem_q [NUM_PATTERNS];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NUM_PATTERNS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (32'(waddr_i) < NUM_PATTERNS)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Out-of-range indices only exist for non-power-of-2 depths; they read as zero.
    always_comb begin
        rdata_o = '0;
        if (32'(raddr_i) < NUM_PATTERNS) begin
            rdata_o = mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/light_dance_sequencer.sv
// Steps through the pattern table driving LightDance: clear, then per entry one load followed by
// shift_len shift cycles with a mode-selected serial input; optionally loops.
module light_dance_sequencer
    import light_dance_sequencer_pkg::*;
#(
    parameter int unsigned NUM_PATTERNS = 8,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CNT_W        = 8,
    localparam int unsigned AW          = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1
) (
    input  logic              clk_i,
    input  logic              arst_ni,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              loop_en_i,
    input  logic [AW-1:0]     seq_len_i,
    input  logic [CNT_W-1:0]  shift_len_i,
    input  logic              cfg_we_i,
    input  logic [AW-1:0]     cfg_addr_i,
    input  logic [DATA_W-1:0] cfg_data_i,
    input  logic [1:0]        cfg_mode_i,
    input  logic [DATA_W-1:0] ld_qdata_i,
    output logic              ld_arst_o,
    output logic              ld_load_o,
    output logic [DATA_W-1:0] ld_pdata_o,
    output logic              ld_din_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [AW-1:0]     cur_idx_o
);

    localparam logic [AW-1:0] LastIdx = AW'(NUM_PATTERNS - 1);

    ld_state_e         state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [AW-1:0]     last_q, last_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tgl_q, tgl_d;
    logic              abort;

    logic              ld_arst_q, ld_load_q, shift_q, busy_q, done_q;
    logic [DATA_W-1:0] ld_pdata_q;
    ld_mode_e          mode_q;
    logic [DATA_W+1:0] rd_entry;

    ld_pattern_table #(
        .NUM_PATTERNS(NUM_PATTERNS),
        .DATA_W      (DATA_W),
        .AW          (AW)
    ) u_table (
        .clk_i  (clk_i),
        .rst_ni (arst_ni),
        .we_i   (cfg_we_i),
        .waddr_i(cfg_addr_i),
        .wdata_i({cfg_mode_i, cfg_data_i}),
        .raddr_i(idx_d),
        .rdata_o(rd_entry)
    );

    assign abort = stop_i && (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        tgl_d   = tgl_q;
        unique case (state_q)
            StIdle: begin
                if (start_i && !stop_i) begin
                    state_d = StClear;
                    idx_d   = '0;
                    last_d  = (32'(seq_len_i) > NUM_PATTERNS - 1) ? LastIdx : seq_len_i;
                    len_d   = shift_len_i;
                end
            end
            StClear: state_d = StLoad;
            StLoad: begin
                tgl_d = 1'b1;
                if (len_q != '0) begin
                    state_d = StShift;
                    cnt_d   = len_q - CNT_W'(1);
                end else begin
                    state_d = StAdv;
                end
            end
            StShift: begin
                tgl_d = ~tgl_q;
                if (cnt_q == '0) begin
                    state_d = StAdv;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StAdv: begin
                if (idx_q != last_q) begin
                    idx_d   = idx_q + AW'(1);
                    state_d = StLoad;
                end else if (loop_en_i) begin
                    idx_d   = '0;
                    state_d = StLoad;
                end else begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d = StIdle;
        end
    end

    // Outputs are decoded from the next state so they line up with the state they belong to.
    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            last_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            tgl_q      <= 1'b0;
            ld_arst_q  <= 1'b0;
            ld_load_q  <= 1'b0;
            ld_pdata_q <= '0;
            mode_q     <= ModeZero;
            shift_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            tgl_q     <= tgl_d;
            ld_arst_q <= (state_d == StClear);
            ld_load_q <= (state_d == StLoad);
            shift_q   <= (state_d == StShift);
            busy_q    <= (state_d != StIdle);
            done_q    <= (state_d == StDone);
            if (state_d == StLoad) begin
                ld_pdata_q <= rd_entry[DATA_W-1:0];
                mode_q     <= ld_mode_e'(rd_entry[DATA_W +: 2]);
            end else if (abort) begin
                ld_pdata_q <= '0;
            end
        end
    end

    // Rotate taps qdata live so the feedback bit is the one LightDance shifts out this cycle.
    assign ld_din_o   = shift_q & din_sel(mode_q, ld_qdata_i[DATA_W-1], tgl_q);
    assign ld_arst_o  = ld_arst_q;
    assign ld_load_o  = ld_load_q;
    assign ld_pdata_o = ld_pdata_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign cur_idx_o  = idx_q;

endmodule
